// File: rtl/sync_fork_tx.sv
// sync_fork_tx: clocked sender that forks one producer word onto two
// independent four-phase bundled-data consumers. Each branch runs its own
// request/acknowledge cycle; the next word is taken only after both branches
// have returned to zero and neither synchronized acknowledge is still high.
module sync_fork_tx #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_req_0,
  input  logic             i_ack_0,
  output logic             o_req_1,
  input  logic             i_ack_1,
  output logic [WIDTH-1:0] o_data
);

  // Top-level handshake states
  localparam logic S_IDLE = 1'b0;
  localparam logic S_HS   = 1'b1;

  // Per-branch four-phase states
  localparam logic [1:0] B_REQ  = 2'd0;
  localparam logic [1:0] B_RTZ  = 2'd1;
  localparam logic [1:0] B_DONE = 2'd2;

  // Acknowledge synchronizers; the MSB is the synchronized level
  logic [SYNC_STAGES-1:0] r_sync_0;
  logic [SYNC_STAGES-1:0] r_sync_1;
  logic                   w_ack_s_0;
  logic                   w_ack_s_1;

  // Control state
  logic                   r_state;
  logic [1:0]             r_br_0;
  logic [1:0]             r_br_1;
  logic                   r_req_0;
  logic                   r_req_1;
  logic                   r_ready;
  logic [WIDTH-1:0]       r_data;

  // Next-state wires
  logic                   w_accept;
  logic [1:0]             w_br_0_nxt;
  logic [1:0]             w_br_1_nxt;
  logic                   w_req_0_nxt;
  logic                   w_req_1_nxt;
  logic                   w_state_nxt;
  logic                   w_ready_nxt;

  // One branch step: an accept restarts the branch with its request high;
  // otherwise REQ waits for ack high (dropping the request), RTZ waits for
  // ack low, and DONE ignores the acknowledge entirely. The unused encoding
  // falls back to DONE with the request low.
  function automatic logic [2:0] branch_step(input logic [1:0] st,
                                             input logic       req,
                                             input logic       ack_s,
                                             input logic       accept);
    logic [1:0] st_n;
    logic       req_n;
    st_n  = st;
    req_n = req;
    if (accept) begin
      st_n  = B_REQ;
      req_n = 1'b1;
    end else begin
      case (st)
        B_REQ: begin
          if (ack_s) begin
            st_n  = B_RTZ;
            req_n = 1'b0;
          end
        end
        B_RTZ: begin
          if (!ack_s) begin
            st_n = B_DONE;
          end
        end
        default: begin
          st_n  = B_DONE;
          req_n = 1'b0;
        end
      endcase
    end
    return {req_n, st_n};
  endfunction

  assign w_ack_s_0 = r_sync_0[SYNC_STAGES-1];
  assign w_ack_s_1 = r_sync_1[SYNC_STAGES-1];

  // A word is taken only from idle with ready already advertised
  assign w_accept = (r_state == S_IDLE) && i_valid && r_ready;

  // Advance both branches independently from their own synchronized acks
  always_comb begin
    {w_req_0_nxt, w_br_0_nxt} = branch_step(r_br_0, r_req_0, w_ack_s_0, w_accept);
    {w_req_1_nxt, w_br_1_nxt} = branch_step(r_br_1, r_req_1, w_ack_s_1, w_accept);
  end

  // Top FSM: leave the handshake on the edge the last branch reaches DONE;
  // ready is withheld while any synchronized ack is still high
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_HS;
        end
      end
      default: begin
        if ((w_br_0_nxt == B_DONE) && (w_br_1_nxt == B_DONE)) begin
          w_state_nxt = S_IDLE;
        end
      end
    endcase
    w_ready_nxt = (w_state_nxt == S_IDLE) && !w_ack_s_0 && !w_ack_s_1;
  end

  // Bring the asynchronous acknowledges into the clk domain
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync_0 <= '0;
      r_sync_1 <= '0;
    end else begin
      r_sync_0 <= {r_sync_0[SYNC_STAGES-2:0], i_ack_0};
      r_sync_1 <= {r_sync_1[SYNC_STAGES-2:0], i_ack_1};
    end
  end

  // Register control state; reset abandons any handshake in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_br_0  <= B_DONE;
      r_br_1  <= B_DONE;
      r_req_0 <= 1'b0;
      r_req_1 <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_br_0  <= w_br_0_nxt;
      r_br_1  <= w_br_1_nxt;
      r_req_0 <= w_req_0_nxt;
      r_req_1 <= w_req_1_nxt;
      r_ready <= w_ready_nxt;
    end
  end

  // Capture the bundled word on accept and hold it for both branches
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= '0;
    end else if (w_accept) begin
      r_data <= i_data;
    end
  end

  assign o_ready = r_ready;
  assign o_req_0 = r_req_0;
  assign o_req_1 = r_req_1;
  assign o_data  = r_data;

endmodule

// File: tb/tb_sync_fork_tx.sv
// tb_sync_fork_tx: directed bench for sync_fork_tx with two behavioural
// four-phase consumers (configurable acknowledge delay, injectable noise).
module tb_sync_fork_tx;

  localparam int WIDTH = 32;
  localparam int SYNC  = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_data;
  logic [WIDTH-1:0] o_data;
  logic             o_req_0;
  logic             i_ack_0;
  logic             o_req_1;
  logic             i_ack_1;

  // Consumer model controls: delay 0 means a combinational (zero-delay) ack
  int   dly0   = 0;
  int   dly1   = 0;
  logic noise0 = 1'b0;
  logic noise1 = 1'b0;
  logic ack_r0 = 1'b0;
  logic ack_r1 = 1'b0;
  int   cnt0   = 0;
  int   cnt1   = 0;

  // Request pulse counters
  int   rise0  = 0;
  int   rise1  = 0;
  logic prev0  = 1'b0;
  logic prev1  = 1'b0;

  int   n_chk  = 0;
  int   n_fail = 0;

  sync_fork_tx #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC)) dut (
    .clk    (clk),
    .rst    (rst),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .i_data (i_data),
    .o_req_0(o_req_0),
    .i_ack_0(i_ack_0),
    .o_req_1(o_req_1),
    .i_ack_1(i_ack_1),
    .o_data (o_data)
  );

  always #5 clk = ~clk;

  assign i_ack_0 = ((dly0 == 0) ? o_req_0 : ack_r0) | noise0;
  assign i_ack_1 = ((dly1 == 0) ? o_req_1 : ack_r1) | noise1;

  // Delayed consumers: ack follows req after dlyN cycles of disagreement
  always @(posedge clk) begin
    if (rst) begin
      ack_r0 <= 1'b0;
      cnt0   <= 0;
    end else if (ack_r0 != o_req_0) begin
      if (cnt0 + 1 >= dly0) begin
        ack_r0 <= o_req_0;
        cnt0   <= 0;
      end else begin
        cnt0 <= cnt0 + 1;
      end
    end else begin
      cnt0 <= 0;
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      ack_r1 <= 1'b0;
      cnt1   <= 0;
    end else if (ack_r1 != o_req_1) begin
      if (cnt1 + 1 >= dly1) begin
        ack_r1 <= o_req_1;
        cnt1   <= 0;
      end else begin
        cnt1 <= cnt1 + 1;
      end
    end else begin
      cnt1 <= 0;
    end
  end

  always @(negedge clk) begin
    if (o_req_0 === 1'b1 && prev0 === 1'b0) rise0 <= rise0 + 1;
    if (o_req_1 === 1'b1 && prev1 === 1'b0) rise1 <= rise1 + 1;
    prev0 <= (o_req_0 === 1'b1);
    prev1 <= (o_req_1 === 1'b1);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag, input int max);
    int k;
    k = 0;
    while (o_ready !== 1'b1 && k < max) begin
      step(1);
      k++;
    end
    check_val(tag, 64'(o_ready), 64'd1);
  endtask

  initial begin
    int          f0, f1, rdy_t, hold_err, data_err, gap_err, req_err;
    int          r0, r1, idx, prev_acc;
    logic        will;
    logic [31:0] words [8];

    rst     = 1'b1;
    i_valid = 1'b0;
    i_data  = '0;
    step(3);
    check_val("rst_ready", 64'(o_ready), 64'd0);
    check_val("rst_req0",  64'(o_req_0), 64'd0);
    check_val("rst_req1",  64'(o_req_1), 64'd0);
    check_val("rst_data",  64'(o_data),  64'd0);
    rst = 1'b0;
    step(1);
    check_val("rst_release_ready", 64'(o_ready), 64'd1);

    // Basic fork, zero-delay consumers, accept at E0
    i_valid = 1'b1;
    i_data  = 32'hA5A5_0001;
    step(1);
    i_valid = 1'b0;
    check_val("basic_data",     64'(o_data),  64'hA5A5_0001);
    check_val("basic_req0_e0",  64'(o_req_0), 64'd1);
    check_val("basic_req1_e0",  64'(o_req_1), 64'd1);
    check_val("basic_ready_e0", 64'(o_ready), 64'd0);
    step(2);
    check_val("basic_req0_e2",  64'(o_req_0), 64'd1);
    check_val("basic_req1_e2",  64'(o_req_1), 64'd1);
    step(1);
    check_val("basic_req0_e3",  64'(o_req_0), 64'd0);
    check_val("basic_req1_e3",  64'(o_req_1), 64'd0);
    step(2);
    check_val("basic_ready_e5", 64'(o_ready), 64'd0);
    check_val("basic_hold_e5",  64'(o_data),  64'hA5A5_0001);
    step(1);
    check_val("basic_ready_e6", 64'(o_ready), 64'd1);
    i_valid = 1'b1;
    i_data  = 32'h1234_5678;
    step(1);
    i_valid = 1'b0;
    check_val("basic_second_data", 64'(o_data),  64'h1234_5678);
    check_val("basic_second_req0", 64'(o_req_0), 64'd1);
    wait_ready("basic_second_done", 20);

    // Skewed branches: fall = dly+SYNC+1, ready = 2*dly_slow+2*SYNC+2
    dly0     = 1;
    dly1     = 20;
    i_valid  = 1'b1;
    i_data   = 32'hC0DE_0002;
    step(1);
    i_valid  = 1'b0;
    f0       = -1;
    f1       = -1;
    rdy_t    = -1;
    hold_err = 0;
    for (int t = 1; t <= 80 && rdy_t < 0; t++) begin
      step(1);
      if (f0 < 0 && o_req_0 == 1'b0) f0 = t;
      if (f1 < 0 && o_req_1 == 1'b0) f1 = t;
      if (o_ready == 1'b1) rdy_t = t;
      if (o_data != 32'hC0DE_0002) hold_err++;
    end
    check_val("skew_fall0", 64'(f0),      64'd4);
    check_val("skew_fall1", 64'(f1),      64'd23);
    check_val("skew_gap",   64'(f1 - f0), 64'd19);
    check_val("skew_ready", 64'(rdy_t),   64'd46);
    check_val("skew_hold",  64'(hold_err), 64'd0);

    // Back-to-back stream of 8 words with i_valid held high
    dly0 = 0;
    dly1 = 0;
    for (int k = 0; k < 8; k++) words[k] = 32'hB0B0_0000 + 32'(k * 17);
    r0       = rise0;
    r1       = rise1;
    idx      = 0;
    prev_acc = -1;
    data_err = 0;
    gap_err  = 0;
    i_valid  = 1'b1;
    i_data   = words[0];
    for (int t = 0; t < 200 && idx < 8; t++) begin
      will = o_ready && i_valid;
      step(1);
      if (will) begin
        if (o_data != words[idx]) data_err++;
        if (prev_acc >= 0 && (t - prev_acc) != 7) gap_err++;
        prev_acc = t;
        idx++;
        if (idx < 8) i_data = words[idx];
        else i_valid = 1'b0;
      end else if (idx > 0 && o_data != words[idx-1]) begin
        data_err++;
      end
    end
    check_val("b2b_count", 64'(idx),      64'd8);
    check_val("b2b_data",  64'(data_err), 64'd0);
    check_val("b2b_gap",   64'(gap_err),  64'd0);
    wait_ready("b2b_done", 20);
    check_val("b2b_pulses0", 64'(rise0 - r0), 64'd8);
    check_val("b2b_pulses1", 64'(rise1 - r1), 64'd8);

    // Stale acknowledge held on branch 1 after completion
    noise1 = 1'b1;
    step(3);
    check_val("stale_ready", 64'(o_ready), 64'd0);
    r0      = rise0;
    r1      = rise1;
    i_valid = 1'b1;
    i_data  = 32'hDEAD_BEEF;
    step(5);
    check_val("stale_noacc_ready", 64'(o_ready), 64'd0);
    check_val("stale_noacc_data",  64'(o_data),  64'(words[7]));
    check_val("stale_noacc_pulse", 64'((rise0 - r0) + (rise1 - r1)), 64'd0);
    noise1 = 1'b0;
    step(2);
    check_val("stale_drop_e2", 64'(o_ready), 64'd0);
    step(1);
    check_val("stale_drop_e3", 64'(o_ready), 64'd1);
    step(1);
    i_valid = 1'b0;
    check_val("stale_accept_data", 64'(o_data), 64'hDEAD_BEEF);
    wait_ready("stale_done", 20);

    // Reset while both branches wait in B_REQ
    dly0    = 30;
    dly1    = 30;
    i_valid = 1'b1;
    i_data  = 32'h0BAD_F00D;
    step(1);
    i_valid = 1'b0;
    check_val("rstmid_busy", 64'({o_req_0, o_req_1}), 64'd3);
    step(2);
    rst = 1'b1;
    step(1);
    check_val("rstmid_req0",  64'(o_req_0), 64'd0);
    check_val("rstmid_req1",  64'(o_req_1), 64'd0);
    check_val("rstmid_data",  64'(o_data),  64'd0);
    check_val("rstmid_ready", 64'(o_ready), 64'd0);
    dly0 = 0;
    dly1 = 0;
    rst  = 1'b0;
    step(1);
    check_val("rstmid_release_ready", 64'(o_ready), 64'd1);

    // Noise on branch 0 while it sits in B_DONE (branch 1 slow)
    dly1     = 10;
    r0       = rise0;
    r1       = rise1;
    i_valid  = 1'b1;
    i_data   = 32'h7E57_0003;
    step(1);
    i_valid  = 1'b0;
    rdy_t    = -1;
    req_err  = 0;
    hold_err = 0;
    for (int t = 1; t <= 60 && rdy_t < 0; t++) begin
      if (t == 10) noise0 = 1'b1;
      if (t == 13) noise0 = 1'b0;
      step(1);
      if (t >= 3 && o_req_0 == 1'b1) req_err++;
      if (o_data != 32'h7E57_0003) hold_err++;
      if (o_ready == 1'b1) rdy_t = t;
    end
    check_val("noise_req0_low", 64'(req_err),    64'd0);
    check_val("noise_ready",    64'(rdy_t),      64'd26);
    check_val("noise_hold",     64'(hold_err),   64'd0);
    check_val("noise_pulses0",  64'(rise0 - r0), 64'd1);
    check_val("noise_pulses1",  64'(rise1 - r1), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
